// File: rtl/regfile_2w_clr.sv
// Two-read / two-write register file with a sequential clear engine.
// After reset the array is zeroed one entry per cycle; Ready rises once every
// entry has been written, so reads can never return X afterwards.
module regfile_2w_clr #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] R_Reg1,
  input  logic [ADDR_W-1:0] R_Reg2,
  output logic [WIDTH-1:0]  R_data1,
  output logic [WIDTH-1:0]  R_data2,
  input  logic [ADDR_W-1:0] W_RegA,
  input  logic [WIDTH-1:0]  W_dataA,
  input  logic              RegWrA,
  input  logic [ADDR_W-1:0] W_RegB,
  input  logic [WIDTH-1:0]  W_dataB,
  input  logic              RegWrB,
  output logic              Ready,
  output logic              Wr_Conflict
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam int unsigned       N_RD     = 2;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nxt;
  logic              ready_nxt;
  logic              conflict_nxt;

  logic              we_a;
  logic              we_b;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0] rd_addr [N_RD];
  logic [WIDTH-1:0]  rd_data [N_RD];

  // Effective write enables: only in READY, never in a reset cycle,
  // and never to the hardwired zero entry.
  always_comb begin
    we_a = 1'b0;
    we_b = 1'b0;
    if (!RST && (state == READY)) begin
      we_a = RegWrA && !(ZERO_REG && (W_RegA == '0));
      we_b = RegWrB && !(ZERO_REG && (W_RegB == '0));
    end
  end

  // Next-state logic for the clear engine and the registered status flags.
  always_comb begin
    state_nxt    = state;
    clr_ptr_nxt  = clr_ptr;
    ready_nxt    = Ready;
    conflict_nxt = 1'b0;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = ADDR_W'(clr_ptr + 1'b1);
        if (clr_ptr == LAST_PTR) begin
          state_nxt = READY;
          ready_nxt = 1'b1;
        end
      end
      READY: begin
        conflict_nxt = we_a && we_b && (W_RegA == W_RegB);
      end
    endcase
  end

  // State register; reset restarts the clear from entry 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      Ready       <= 1'b0;
      Wr_Conflict <= 1'b0;
    end else begin
      state       <= state_nxt;
      clr_ptr     <= clr_ptr_nxt;
      Ready       <= ready_nxt;
      Wr_Conflict <= conflict_nxt;
    end
  end

  // Storage array: clear one entry per cycle, then accept writes; B issued last so it wins.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        if (we_a) begin
          mem[W_RegA] <= W_dataA;
        end
        if (we_b) begin
          mem[W_RegB] <= W_dataB;
        end
      end
    end
  end

  assign rd_addr[0] = R_Reg1;
  assign rd_addr[1] = R_Reg2;

  // Asynchronous read ports with optional write-through bypass (port B has priority).
  always_comb begin
    for (int p = 0; p < int'(N_RD); p++) begin
      rd_data[p] = mem[rd_addr[p]];
      if ((state == CLEAR) || (ZERO_REG && (rd_addr[p] == '0))) begin
        rd_data[p] = '0;
      end else if (BYPASS && we_b && (W_RegB == rd_addr[p])) begin
        rd_data[p] = W_dataB;
      end else if (BYPASS && we_a && (W_RegA == rd_addr[p])) begin
        rd_data[p] = W_dataA;
      end
    end
  end

  assign R_data1 = rd_data[0];
  assign R_data2 = rd_data[1];

endmodule
